parity_rr_arbiter: RTL and testbench

Shares one N-bit parity generator among `NUM_REQ` requesters using round-robin arbitration. Each requester presents a data word under a valid/ready handshake. The block grants one requester per cycle and computes odd and even parity on the granted word. It returns the word, both parity bits and the requester ID through a single registered output stage with its own valid/ready handshake. It sits between the byte-producing clients and any downstream framer or checker that consumes parity-tagged words.

---
 rtl/parity_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_parity_rr_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/parity_rr_arbiter.sv
// Round-robin share of one parity generator among NUM_REQ requesters,
// with a single registered output stage under valid/ready.
module parity_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  output logic                      out_even_parity,
  output logic                      out_odd_parity
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int CW = ID_W + 1;
  localparam logic [CW-1:0]   NREQ_C  = CW'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_nxt;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_found;
  logic              accept;
  logic              xfer;
  logic [CW-1:0]     cand;
  logic [DATA_W-1:0] gnt_data;

  // Scan upward from ptr; the wrap uses a compare so odd NUM_REQ works.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + CW'(i);
      if (cand >= NREQ_C)
        cand = cand - NREQ_C;
      if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i))
        gnt_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign accept = (state == EMPTY) || out_ready;
  assign xfer   = rst_n && accept && gnt_found;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = xfer && (gnt_idx == ID_W'(i));
    end
  end

  assign ptr_nxt = (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= EMPTY;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: begin
        if (xfer)
          state_nxt = FULL;
      end
      FULL: begin
        if (xfer)
          state_nxt = FULL;
        else if (out_ready)
          state_nxt = EMPTY;
      end
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    unique case (state)
      EMPTY: out_valid = 1'b0;
      FULL:  out_valid = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr             <= '0;
      out_data        <= '0;
      out_id          <= '0;
      out_even_parity <= 1'b0;
      out_odd_parity  <= 1'b1;
    end else if (xfer) begin
      ptr             <= ptr_nxt;
      out_data        <= gnt_data;
      out_id          <= gnt_idx;
      out_even_parity <= ^gnt_data;
      out_odd_parity  <= ~^gnt_data;
    end
  end

endmodule

// File: tb/tb_parity_rr_arbiter.sv
// Bench for parity_rr_arbiter: fixed vector tables, corner sequences
// and randomized traffic against a round-robin reference model.
module tb_parity_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [1:0]    out_id;
  logic          out_even_parity;
  logic          out_odd_parity;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  parity_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_id(out_id),
    .out_even_parity(out_even_parity),
    .out_odd_parity(out_odd_parity)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [1:0]  exp_id;
    logic [7:0]  exp_data;
    logic        exp_even;
    logic        exp_odd;
  } vec_t;

  vec_t tab_a[2];
  vec_t tab_b[13];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Entered just after a rising edge; checks req_ready mid-cycle,
  // then the registered outputs just after the next edge.
  task automatic apply_vec(input vec_t v, input string tag);
    req_valid = v.valid;
    req_data  = v.data;
    out_ready = v.ordy;
    #4;
    chk({tag, ".req_ready"}, 64'(req_ready), 64'(v.exp_ready));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(v.exp_valid));
    if (v.exp_valid) begin
      chk({tag, ".out_id"}, 64'(out_id), 64'(v.exp_id));
      chk({tag, ".out_data"}, 64'(out_data), 64'(v.exp_data));
      chk({tag, ".even"}, 64'(out_even_parity), 64'(v.exp_even));
      chk({tag, ".odd"}, 64'(out_odd_parity), 64'(v.exp_odd));
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.req_ready", 64'(req_ready), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_data", 64'(out_data), 64'd0);
    chk("rst.out_id", 64'(out_id), 64'd0);
    chk("rst.even", 64'(out_even_parity), 64'd0);
    chk("rst.odd", 64'(out_odd_parity), 64'd1);
    rst_n     = 1'b1;
    req_valid = '0;
  endtask

  // Reference model state
  bit        m_full;
  int        m_ptr;
  logic [7:0] m_data;
  int        m_id;

  task automatic run_random(input int cycles);
    logic [3:0] v;
    logic [31:0] d;
    logic        r;
    int          g;
    logic [3:0]  exp_rdy;
    bit          acc;
    for (int c = 0; c < cycles; c++) begin
      v = 4'($urandom_range(0, 15));
      d = $urandom;
      r = 1'($urandom_range(0, 3) != 0);
      req_valid = v;
      req_data  = d;
      out_ready = r;
      g = -1;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (g < 0 && v[idx])
          g = idx;
      end
      acc = !m_full || r;
      exp_rdy = (acc && g >= 0) ? 4'(1 << g) : 4'b0000;
      #4;
      chk("rnd.req_ready", 64'(req_ready), 64'(exp_rdy));
      @(posedge clk);
      #1;
      if (acc && g >= 0) begin
        m_full = 1'b1;
        m_data = d[g*8 +: 8];
        m_id   = g;
        m_ptr  = (g + 1) % N;
      end else if (r) begin
        m_full = 1'b0;
      end
      chk("rnd.out_valid", 64'(out_valid), 64'(m_full));
      if (m_full) begin
        chk("rnd.out_id", 64'(out_id), 64'(m_id));
        chk("rnd.out_data", 64'(out_data), 64'(m_data));
        chk("rnd.even", 64'(out_even_parity),
            64'($countones(m_data) % 2));
        chk("rnd.odd", 64'(out_odd_parity),
            64'(1 - ($countones(m_data) % 2)));
      end
    end
  endtask

  localparam logic [31:0] ROT = 32'h2A38E00E;
  localparam logic [31:0] DL  = 32'h2A38E0AA;

  initial begin
    tab_a[0] = '{4'b0100, 32'h0030_0000, 1'b1, 4'b0100,
                 1'b1, 2'd2, 8'h30, 1'b0, 1'b1};
    tab_a[1] = '{4'b0000, 32'h0030_0000, 1'b1, 4'b0000,
                 1'b0, 2'd0, 8'h00, 1'b0, 1'b0};

    tab_b[0]  = '{4'b1111, ROT, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h0E, 1'b1, 1'b0};
    tab_b[1]  = '{4'b1111, ROT, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hE0, 1'b1, 1'b0};
    tab_b[2]  = '{4'b1111, ROT, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h38, 1'b1, 1'b0};
    tab_b[3]  = '{4'b1111, ROT, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h2A, 1'b1, 1'b0};
    tab_b[4]  = '{4'b1111, ROT, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h0E, 1'b1, 1'b0};
    tab_b[5]  = '{4'b1010, ROT, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h0E, 1'b1, 1'b0};
    tab_b[6]  = '{4'b1010, ROT, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h0E, 1'b1, 1'b0};
    tab_b[7]  = '{4'b1010, ROT, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h0E, 1'b1, 1'b0};
    tab_b[8]  = '{4'b1010, ROT, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h0E, 1'b1, 1'b0};
    tab_b[9]  = '{4'b1010, ROT, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hE0, 1'b1, 1'b0};
    tab_b[10] = '{4'b1010, ROT, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h2A, 1'b1, 1'b0};
    tab_b[11] = '{4'b0001, DL,  1'b1, 4'b0001, 1'b1, 2'd0, 8'hAA, 1'b0, 1'b1};
    tab_b[12] = '{4'b0000, DL,  1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 2; i++)
      apply_vec(tab_a[i], "single");

    do_reset();
    for (int i = 0; i < 5; i++) begin
      req_valid = '0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("idle.out_valid", 64'(out_valid), 64'd0);
    end
    for (int i = 0; i < 13; i++)
      apply_vec(tab_b[i], "tab");

    // Load requester 3, then reset asynchronously while FULL.
    req_valid = 4'b1000;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("mid.pre_valid", 64'(out_valid), 64'd1);
    chk("mid.pre_id", 64'(out_id), 64'd3);
    req_valid = 4'b1111;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.async_valid", 64'(out_valid), 64'd0);
    chk("mid.async_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #2;
    chk("mid.first_ready", 64'(req_ready), 64'b0001);
    @(posedge clk);
    #1;
    chk("mid.first_id", 64'(out_id), 64'd0);
    chk("mid.first_valid", 64'(out_valid), 64'd1);

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_full = 1'b0;
    m_ptr  = 0;
    m_data = '0;
    m_id   = 0;
    run_random(400);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
